// File: rtl/edge_scan_if.sv
// ============================================================================
// edge_scan_if
// Bundles the configuration, control and status signals of edge_scan_ctrl.
//   master : drives the channel inputs, scan configuration and start/abort,
//            and selects which result to read.
//   slave  : the scan controller. It returns the selected result, busy,
//            cur_ch, the done/ovf flags and the end-of-pass irq.
// The NCH, CW and GW parameters must match those of the controller instance.
// ============================================================================
interface edge_scan_if #(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int GW  = 16
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] ch_in;
    logic [NCH-1:0] ch_mask;
    logic [GW-1:0]  gate_len;
    logic [1:0]     edge_mode;
    logic           start;
    logic           continuous;
    logic           abort;
    logic [CHW-1:0] rd_ch;
    logic [CW-1:0]  rd_data;
    logic           busy;
    logic [CHW-1:0] cur_ch;
    logic [NCH-1:0] done_flags;
    logic [NCH-1:0] ovf_flags;
    logic           irq;

    modport master (
        output ch_in, ch_mask, gate_len, edge_mode, start, continuous, abort, rd_ch,
        input  rd_data, busy, cur_ch, done_flags, ovf_flags, irq
    );

    modport slave (
        input  ch_in, ch_mask, gate_len, edge_mode, start, continuous, abort, rd_ch,
        output rd_data, busy, cur_ch, done_flags, ovf_flags, irq
    );
endinterface

// File: rtl/edge_scan_ctrl.sv
// ============================================================================
// edge_scan_ctrl
// Scans a set of asynchronous input channels one at a time. A single edge
// counter is shared by all channels: each selected channel is gated for
// gate_len clocks and its edge count is stored in a per-channel result.
//
// Ports
//   clk  : clock; all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : edge_scan_if.slave
//          inputs  ch_in, ch_mask, gate_len, edge_mode, start, continuous,
//                  abort, rd_ch
//          outputs rd_data (combinational result[rd_ch]), busy, cur_ch,
//                  done_flags, ovf_flags, irq (one-cycle end-of-pass pulse)
//
// Build option
//   EDGE_SCAN_OVF_EN : when defined, ovf_flags[ch] is set for every channel
//                      whose counter saturated during its gate. When it is
//                      not defined, ovf_flags is tied to 0. The counter
//                      saturates in both builds.
// ============================================================================
module edge_scan_ctrl #(
    parameter int NCH = 8,
    parameter int CW  = 16,
    parameter int GW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    edge_scan_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] sync1_q, sync1_d;
    logic [NCH-1:0] sync2_q, sync2_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [GW-1:0]  gate_q, gate_d;
    logic [1:0]     mode_q, mode_d;
    logic [CHW-1:0] cur_ch_q, cur_ch_d;
    logic           prev_q, prev_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  timer_q, timer_d;
    logic [NCH-1:0] done_q, done_d;
    logic           irq_q, irq_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  result_q [NCH];
    logic [CW-1:0]  result_d [NCH];
`ifdef EDGE_SCAN_OVF_EN
    logic [NCH-1:0] ovf_q, ovf_d;
`endif

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [CHW:0] first_set(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    logic [CHW:0] lo_new, lo_mask, nxt_mask;
    logic         sel_bit, edge_hit;

    assign lo_new   = first_set(bus.ch_mask, 0);
    assign lo_mask  = first_set(mask_q, 0);
    assign nxt_mask = first_set(mask_q, int'(cur_ch_q) + 1);

    // In SETTLE cur_ch already points at the new channel, so the same
    // expression provides the prev preload and the per-cycle GATE sample.
    assign sel_bit = sync2_q[cur_ch_q];

    always_comb begin
        case (mode_q)
            2'b00:   edge_hit = sel_bit & ~prev_q;
            2'b01:   edge_hit = ~sel_bit & prev_q;
            default: edge_hit = sel_bit ^ prev_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sync1_d  = bus.ch_in;
        sync2_d  = sync1_q;
        mask_d   = mask_q;
        gate_d   = gate_q;
        mode_d   = mode_q;
        cur_ch_d = cur_ch_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        done_d   = done_q;
        irq_d    = 1'b0;
        result_d = result_q;
`ifdef EDGE_SCAN_OVF_EN
        ovf_d    = ovf_q;
`endif

        if (state_q != IDLE && bus.abort) begin
            // Leave the results and flags as they are; only the FSM stops.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && lo_new[CHW]) begin
                        mask_d   = bus.ch_mask;
                        gate_d   = bus.gate_len;
                        mode_d   = bus.edge_mode;
                        done_d   = '0;
`ifdef EDGE_SCAN_OVF_EN
                        ovf_d    = '0;
`endif
                        cur_ch_d = lo_new[CHW-1:0];
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    prev_d  = sel_bit;
                    cnt_d   = '0;
                    timer_d = (gate_q == '0) ? GW'(1) : gate_q;
                    state_d = GATE;
                end
                GATE: begin
                    prev_d = sel_bit;
                    if (edge_hit && cnt_q != '1) cnt_d = cnt_q + CW'(1);
                    if (timer_q <= GW'(1)) state_d = STORE;
                    else                   timer_d = timer_q - GW'(1);
                end
                STORE: begin
                    result_d[cur_ch_q] = cnt_q;
                    done_d[cur_ch_q]   = 1'b1;
`ifdef EDGE_SCAN_OVF_EN
                    // The counter never decreases, so an all-ones value here
                    // means it reached saturation at some point in the gate.
                    if (cnt_q == '1) ovf_d[cur_ch_q] = 1'b1;
`endif
                    if (nxt_mask[CHW]) begin
                        cur_ch_d = nxt_mask[CHW-1:0];
                        state_d  = SETTLE;
                    end else begin
                        irq_d = 1'b1;
                        if (bus.continuous && lo_mask[CHW]) begin
                            cur_ch_d = lo_mask[CHW-1:0];
                            state_d  = SETTLE;
                        end else begin
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            mask_q   <= '0;
            gate_q   <= '0;
            mode_q   <= '0;
            cur_ch_q <= '0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
            done_q   <= '0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) result_q[i] <= '0;
`ifdef EDGE_SCAN_OVF_EN
            ovf_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            mask_q   <= mask_d;
            gate_q   <= gate_d;
            mode_q   <= mode_d;
            cur_ch_q <= cur_ch_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
            result_q <= result_d;
`ifdef EDGE_SCAN_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.rd_data    = result_q[bus.rd_ch];
    assign bus.busy       = busy_q;
    assign bus.cur_ch     = cur_ch_q;
    assign bus.done_flags = done_q;
    assign bus.irq        = irq_q;
`ifdef EDGE_SCAN_OVF_EN
    assign bus.ovf_flags  = ovf_q;
`else
    assign bus.ovf_flags  = '0;
`endif

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// ============================================================================
// tb_edge_scan_ctrl
// Directed bench for edge_scan_ctrl. dut0 uses the default widths. dut1 uses
// CW=4 so that counter saturation can be reached with a short pulse train.
// ============================================================================
module tb_edge_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_scan_if #(.NCH(8), .CW(16), .GW(16)) bus0 ();
    edge_scan_if #(.NCH(8), .CW(4),  .GW(16)) bus1 ();

    edge_scan_ctrl #(.NCH(8), .CW(16), .GW(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    edge_scan_ctrl #(.NCH(8), .CW(4),  .GW(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int errors = 0;
    int checks = 0;

`ifdef EDGE_SCAN_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start0(input logic [7:0] mask, input logic [15:0] gl,
                          input logic [1:0] mode, input logic cont);
        bus0.ch_mask    = mask;
        bus0.gate_len   = gl;
        bus0.edge_mode  = mode;
        bus0.continuous = cont;
        bus0.start      = 1'b1;
        tick();
        bus0.start      = 1'b0;
    endtask

    task automatic pulse0(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            bus0.ch_in[ch] = 1'b1;
            tick(); tick();
            bus0.ch_in[ch] = 1'b0;
            tick(); tick();
        end
    endtask

    task automatic wait_idle0(input int max, output int irqs, output bit ok);
        irqs = 0;
        ok   = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus0.irq) irqs++;
            if (!bus0.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        bus0.rd_ch = 3'd0;
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus0.busy); end
        checks++; if (bus0.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", bus0.irq); end
        checks++; if (bus0.cur_ch !== 3'd0) begin errors++; $display("FAIL reset_cur_ch: got %0d expected 0", bus0.cur_ch); end
        checks++; if (bus0.done_flags !== 8'h00) begin errors++; $display("FAIL reset_done: got %h expected 00", bus0.done_flags); end
        checks++; if (bus0.ovf_flags !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h expected 00", bus0.ovf_flags); end
        checks++; if (bus0.rd_data !== 16'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", bus0.rd_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic_scan();
        int  irqs;
        int  irqs2;
        bit  ok;
        bit  seen;
        irqs = 0;
        seen = 1'b0;
        start0(8'h05, 16'd100, 2'b00, 1'b0);
        tick(); tick(); tick();
        pulse0(0, 10);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus0.irq) irqs++;
            if (bus0.cur_ch == 3'd2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL basic_reach_ch2: got timeout expected cur_ch=2"); end
        checks++; if (bus0.done_flags !== 8'h01) begin errors++; $display("FAIL basic_done_mid: got %h expected 01", bus0.done_flags); end
        tick(); tick(); tick();
        pulse0(2, 3);
        wait_idle0(200, irqs2, ok);
        irqs += irqs2;
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle: got timeout expected busy=0"); end
        checks++; if (irqs != 1) begin errors++; $display("FAIL basic_irq_count: got %0d expected 1", irqs); end
        bus0.rd_ch = 3'd0; #1;
        checks++; if (bus0.rd_data !== 16'd10) begin errors++; $display("FAIL basic_result0: got %0d expected 10", bus0.rd_data); end
        bus0.rd_ch = 3'd2; #1;
        checks++; if (bus0.rd_data !== 16'd3) begin errors++; $display("FAIL basic_result2: got %0d expected 3", bus0.rd_data); end
        checks++; if (bus0.done_flags !== 8'h05) begin errors++; $display("FAIL basic_done: got %h expected 05", bus0.done_flags); end
        checks++; if (bus0.ovf_flags !== 8'h00) begin errors++; $display("FAIL basic_ovf: got %h expected 00", bus0.ovf_flags); end
        tick();
        checks++; if (bus0.irq !== 1'b0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL basic_after: got irq=%0b busy=%0b expected 0 0", bus0.irq, bus0.busy); end
        $display("test_basic_scan done");
    endtask

    task automatic test_edge_modes();
        int irqs;
        bit ok;
        start0(8'h02, 16'd60, 2'b10, 1'b0);
        tick(); tick(); tick();
        pulse0(1, 4);
        wait_idle0(200, irqs, ok);
        bus0.rd_ch = 3'd1; #1;
        checks++; if (!ok || bus0.rd_data !== 16'd8) begin errors++; $display("FAIL mode_both: got %0d (idle=%0b) expected 8", bus0.rd_data, ok); end
        start0(8'h02, 16'd60, 2'b01, 1'b0);
        tick(); tick(); tick();
        pulse0(1, 4);
        wait_idle0(200, irqs, ok);
        bus0.rd_ch = 3'd1; #1;
        checks++; if (!ok || bus0.rd_data !== 16'd4) begin errors++; $display("FAIL mode_fall: got %0d (idle=%0b) expected 4", bus0.rd_data, ok); end
        checks++; if (bus0.done_flags !== 8'h02) begin errors++; $display("FAIL mode_done: got %h expected 02", bus0.done_flags); end
        bus0.rd_ch = 3'd0; #1;
        checks++; if (bus0.rd_data !== 16'd10) begin errors++; $display("FAIL persist_result0: got %0d expected 10", bus0.rd_data); end
        $display("test_edge_modes done");
    endtask

    task automatic test_gate_len();
        int n;
        int irqs;
        logic [15:0] gl_tab [2];
        int          exp_tab[2];
        gl_tab[0] = 16'd0;  exp_tab[0] = 3;
        gl_tab[1] = 16'd10; exp_tab[1] = 12;
        for (int k = 0; k < 2; k++) begin
            start0(8'h01, gl_tab[k], 2'b00, 1'b0);
            n = bus0.busy ? 1 : 0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (bus0.busy) n++;
                else break;
            end
            checks++; if (n != exp_tab[k]) begin errors++; $display("FAIL gate_busy_len_%0d: got %0d expected %0d", gl_tab[k], n, exp_tab[k]); end
        end
        start0(8'h00, 16'd20, 2'b00, 1'b0);
        n = 0;
        irqs = 0;
        if (bus0.busy) n++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus0.busy) n++;
            if (bus0.irq) irqs++;
        end
        checks++; if (n != 0 || irqs != 0) begin errors++; $display("FAIL zero_mask: got busy_cycles=%0d irqs=%0d expected 0 0", n, irqs); end
        $display("test_gate_len done");
    endtask

    task automatic test_continuous();
        int c;
        int nirq;
        int t[2];
        int irqs;
        bit ok;
        logic [2:0] ch13;
        logic [2:0] ch25;
        c = 1;
        nirq = 0;
        t[0] = 0; t[1] = 0;
        ch13 = 3'd0; ch25 = 3'd7;
        start0(8'h81, 16'd10, 2'b00, 1'b1);
        for (int i = 0; i < 200; i++) begin
            tick();
            c++;
            if (c == 13) ch13 = bus0.cur_ch;
            if (c == 25) ch25 = bus0.cur_ch;
            if (bus0.irq) begin
                t[nirq] = c;
                nirq++;
                if (nirq == 2) break;
            end
        end
        checks++; if (ch13 !== 3'd7) begin errors++; $display("FAIL cont_ch7: got %0d expected 7", ch13); end
        checks++; if (ch25 !== 3'd0) begin errors++; $display("FAIL cont_ch0: got %0d expected 0", ch25); end
        checks++; if (t[0] != 25) begin errors++; $display("FAIL cont_irq1: got cycle %0d expected 25", t[0]); end
        checks++; if (t[1] != 49) begin errors++; $display("FAIL cont_irq2: got cycle %0d expected 49", t[1]); end
        bus0.continuous = 1'b0;
        wait_idle0(100, irqs, ok);
        checks++; if (!ok || irqs != 1) begin errors++; $display("FAIL cont_stop: got idle=%0b irqs=%0d expected 1 1", ok, irqs); end
        $display("test_continuous done");
    endtask

    task automatic test_abort();
        int irqs;
        bit ok;
        start0(8'h04, 16'd60, 2'b00, 1'b0);
        tick(); tick(); tick();
        pulse0(2, 5);
        wait_idle0(200, irqs, ok);
        bus0.rd_ch = 3'd2; #1;
        checks++; if (!ok || bus0.rd_data !== 16'd5) begin errors++; $display("FAIL abort_prior: got %0d expected 5", bus0.rd_data); end
        start0(8'h04, 16'd60, 2'b00, 1'b0);
        tick(); tick(); tick();
        pulse0(2, 2);
        bus0.abort = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.abort = 1'b0;
        bus0.start = 1'b0;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", bus0.busy); end
        checks++; if (bus0.rd_data !== 16'd5) begin errors++; $display("FAIL abort_result2: got %0d expected 5", bus0.rd_data); end
        checks++; if (bus0.done_flags !== 8'h00) begin errors++; $display("FAIL abort_done: got %h expected 00", bus0.done_flags); end
        irqs = bus0.irq ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus0.irq) irqs++;
        end
        checks++; if (irqs != 0 || bus0.busy !== 1'b0) begin errors++; $display("FAIL abort_irq: got irqs=%0d busy=%0b expected 0 0", irqs, bus0.busy); end
        $display("test_abort done");
    endtask

    task automatic test_saturation();
        bit ok;
        ok = 1'b0;
        bus1.ch_mask   = 8'h08;
        bus1.gate_len  = 16'd100;
        bus1.edge_mode = 2'b00;
        bus1.start     = 1'b1;
        tick();
        bus1.start     = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            bus1.ch_in[3] = 1'b1;
            tick(); tick();
            bus1.ch_in[3] = 1'b0;
            tick(); tick();
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!bus1.busy) begin
                ok = 1'b1;
                break;
            end
        end
        bus1.rd_ch = 3'd3; #1;
        checks++; if (!ok || bus1.rd_data !== 4'd15) begin errors++; $display("FAIL sat_result3: got %0d (idle=%0b) expected 15", bus1.rd_data, ok); end
        checks++; if (bus1.ovf_flags[3] !== OVF_EXP) begin errors++; $display("FAIL sat_ovf3: got %0b expected %0b", bus1.ovf_flags[3], OVF_EXP); end
        checks++; if (bus1.done_flags !== 8'h08) begin errors++; $display("FAIL sat_done: got %h expected 08", bus1.done_flags); end
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid_gate();
        start0(8'h08, 16'd50, 2'b00, 1'b0);
        tick(); tick(); tick();
        pulse0(3, 3);
        checks++; if (bus0.busy !== 1'b1 || bus0.cur_ch !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got busy=%0b cur_ch=%0d expected 1 3", bus0.busy, bus0.cur_ch); end
        #2;
        rst = 1'b1;
        bus0.rd_ch = 3'd2;
        bus1.rd_ch = 3'd3;
        #1;
        checks++; if (bus0.busy !== 1'b0 || bus0.irq !== 1'b0) begin errors++; $display("FAIL rstmid_busy_irq: got %0b %0b expected 0 0", bus0.busy, bus0.irq); end
        checks++; if (bus0.cur_ch !== 3'd0) begin errors++; $display("FAIL rstmid_cur_ch: got %0d expected 0", bus0.cur_ch); end
        checks++; if (bus0.done_flags !== 8'h00 || bus0.ovf_flags !== 8'h00) begin errors++; $display("FAIL rstmid_flags: got done=%h ovf=%h expected 00 00", bus0.done_flags, bus0.ovf_flags); end
        checks++; if (bus0.rd_data !== 16'd0) begin errors++; $display("FAIL rstmid_result2: got %0d expected 0", bus0.rd_data); end
        checks++; if (bus1.rd_data !== 4'd0 || bus1.ovf_flags !== 8'h00) begin errors++; $display("FAIL rstmid_dut1: got result=%0d ovf=%h expected 0 00", bus1.rd_data, bus1.ovf_flags); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("test_reset_mid_gate done");
    endtask

    initial begin
        bus0.ch_in = '0; bus0.ch_mask = '0; bus0.gate_len = '0; bus0.edge_mode = '0;
        bus0.start = 1'b0; bus0.continuous = 1'b0; bus0.abort = 1'b0; bus0.rd_ch = '0;
        bus1.ch_in = '0; bus1.ch_mask = '0; bus1.gate_len = '0; bus1.edge_mode = '0;
        bus1.start = 1'b0; bus1.continuous = 1'b0; bus1.abort = 1'b0; bus1.rd_ch = '0;
        test_reset();
        test_basic_scan();
        test_edge_modes();
        test_gate_len();
        test_continuous();
        test_abort();
        test_saturation();
        test_reset_mid_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/edge_scan_ctrl.md
EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of input channels sharing the one edge counter.
REQ-002 Parameter CW, default 16, edge counter and result width.
REQ-003 Parameter GW, default 16, gate length width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ch_in  input  NCH  raw asynchronous edge inputs.
REQ-007 ch_mask  input  NCH  channels included in a scan.
REQ-008 gate_len  input  GW  gate window in clk cycles.
REQ-009 edge_mode  input  2  00 rising, 01 falling, 1x both edges.
REQ-010 start  input  1  single-cycle scan start pulse.
REQ-011 continuous  input  1  1 = repeat scan passes.
REQ-012 abort  input  1  single-cycle scan abort pulse.
REQ-013 rd_ch  input  clog2(NCH)  result read select.
REQ-014 rd_data  output  CW  result[rd_ch], combinational.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 cur_ch  output  clog2(NCH)  channel currently selected.
REQ-017 done_flags  output  NCH  bit set when that channel's result is written.
REQ-018 ovf_flags  output  NCH  per-channel saturation flags.
REQ-019 irq  output  1  one-cycle pulse at end of each scan pass.

Function
REQ-020 Every ch_in bit SHALL pass a 2-flop synchronizer; edge detection uses the synchronized bit of cur_ch against a prev register.
REQ-021 FSM states SHALL be IDLE, SETTLE, GATE, STORE.
REQ-022 IDLE: start with latched-eligible ch_mask != 0 SHALL latch ch_mask, gate_len, edge_mode; clear done_flags and ovf_flags; select lowest set mask bit; enter SETTLE.
REQ-023 start with ch_mask == 0 SHALL be ignored (stay IDLE, no irq); start while busy SHALL be ignored.
REQ-024 SETTLE SHALL last exactly 1 cycle, load prev with the new channel's synchronized level, clear the counter, load the gate timer.
REQ-025 GATE SHALL last exactly max(gate_len,1) cycles; each cycle a selected edge increments the counter.
REQ-026 Counter SHALL saturate at 2^CW-1, never wrap.
REQ-027 STORE (1 cycle) SHALL write counter to result[cur_ch] and set done_flags[cur_ch].
REQ-028 From STORE, next set bit of latched mask above cur_ch SHALL be selected -> SETTLE.
REQ-029 If none remains, irq SHALL pulse next cycle; continuous=1 (sampled in STORE) -> lowest set bit, SETTLE, without clearing flags; else -> IDLE.
REQ-030 Changes to ch_mask, gate_len, edge_mode during a scan SHALL take effect only at the next start.
REQ-031 abort in any busy state SHALL return to IDLE next cycle; current channel's result and flags unchanged, no irq; abort wins over simultaneous start.
REQ-032 Results SHALL persist across scans until overwritten or reset.

Reset
REQ-033 rst SHALL force IDLE; busy, irq, cur_ch, counter, timer, done_flags, ovf_flags, all results to 0; synchronizers and prev to 0.

Configuration
REQ-034 Macro EDGE_SCAN_OVF_EN defined: ovf_flags[cur_ch] SHALL be set in STORE when the counter reached saturation during that gate.
REQ-035 EDGE_SCAN_OVF_EN undefined: ovf_flags SHALL be constant 0, no saturation-tracking logic; saturation itself still applies.

Verification
REQ-036 mask=0x05, gate_len=100, mode=00, 10 rising pulses on ch0, 3 on ch2, single pass -> result0=10, result2=3, done_flags=0x05, one irq, busy low after.
REQ-037 mode=1x, 4 full pulses on ch1, mask=0x02 -> result1=8; mode=01 same stimulus -> 4.
REQ-038 CW=4, 20 rising edges on ch3 in gate -> result3=15; ovf_flags[3]=1 with EDGE_SCAN_OVF_EN, 0 without.
REQ-039 continuous=1, mask=0x81, gate_len=10 -> cur_ch alternates 0,7; irq every 24 cycles; deassert continuous -> IDLE after current pass.
REQ-040 abort mid-GATE on ch2 with prior result2=5 -> next cycle IDLE, result2=5, done_flags[2]=0, no irq.
REQ-041 gate_len=0 -> GATE lasts 1 cycle; start with mask=0 -> busy stays 0; rst asserted mid-GATE -> all outputs 0 immediately.
